obi_instr_mem: RTL

//  Instruction-side memory for the cv32e40p core. It answers the core's OBI fetch port
//  (instr_req/gnt/addr -> instr_rvalid/rdata) with a fixed, configurable read latency.

---
 rtl/obi_instr_mem.sv | 116 +++++++++++
 1 files changed

// File: rtl/obi_instr_mem.sv
// Instruction memory on the cv32e40p OBI fetch port: fixed LATENCY read pipeline, bounded outstanding fetches,
// side preload port. Optional deterministic grant stalls when IMEM_GNT_STALL_EN is defined.
module obi_instr_mem #(
    parameter int unsigned DEPTH           = 1024,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] OOB_DATA        = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     instr_req_i,
    output logic                     instr_gnt_o,
    input  logic [31:0]              instr_addr_i,
    output logic                     instr_rvalid_o,
    output logic [31:0]              instr_rdata_o,
    output logic                     instr_err_o,
    input  logic                     prog_we_i,
    input  logic [$clog2(DEPTH)-1:0] prog_addr_i,
    input  logic [31:0]              prog_wdata_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] idx;
    logic          oob;
    logic [31:0]   rd_dat;
    logic          accept;
    logic          retire;
    logic          stall;

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] err_q;
    logic [31:0]        dat_q [LATENCY];

    logic [CW-1:0] cnt_q, cnt_d;

    logic unused_addr;
    assign unused_addr = ^instr_addr_i[1:0];

    assign idx    = instr_addr_i[AW+1:2];
    assign oob    = |instr_addr_i[31:AW+2];
    assign rd_dat = oob ? OOB_DATA : mem_q[idx];

    assign instr_gnt_o = !rst_i && (cnt_q < CW'(MAX_OUTSTANDING)) && !stall;
    assign accept      = instr_req_i && instr_gnt_o;
    assign retire      = vld_q[LATENCY-1];

`ifdef IMEM_GNT_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign stall  = (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    // Array is deliberately not reset so preloaded programs survive a core reset.
    always_ff @(posedge clk_i) begin
        if (prog_we_i) begin
            mem_q[prog_addr_i] <= prog_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= accept;
            err_q[0] <= accept && oob;
            if (accept) begin
                dat_q[0] <= rd_dat;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, retire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_rvalid_o = vld_q[LATENCY-1];
    assign instr_rdata_o  = dat_q[LATENCY-1];
    assign instr_err_o    = err_q[LATENCY-1];

endmodule
